// File: rtl/acc_bias_act_pipe_if.sv
// acc_bias_act_pipe_if: accumulator input stream and requantised result stream
interface acc_bias_act_pipe_if #(
    parameter int CH = 32,
    parameter int IN_W = 22,
    parameter int OUT_W = 8
);
    logic                 i_in_valid;
    logic                 o_in_ready;
    logic                 i_in_last;
    logic [CH*IN_W-1:0]   i_in_data;
    logic [CH*IN_W-1:0]   i_bias;
    logic                 o_out_valid;
    logic                 i_out_ready;
    logic [CH*OUT_W-1:0]  o_out_data;
    logic                 o_out_last;
    modport master (
        output i_in_valid, i_in_last, i_in_data, i_bias, i_out_ready,
        input  o_in_ready, o_out_valid, o_out_data, o_out_last
    );
    modport slave (
        input  i_in_valid, i_in_last, i_in_data, i_bias, i_out_ready,
        output o_in_ready, o_out_valid, o_out_data, o_out_last
    );
endinterface

// File: rtl/acc_bias_act_pipe.sv
// acc_bias_act_pipe: per-lane bias add, rounding requantise, ReLU/saturate, credit-gated output FIFO
module acc_bias_act_pipe #(
    parameter int CH = 32,
    parameter int IN_W = 22,
    parameter int OUT_W = 8,
    parameter int SHIFT_W = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SHIFT_W-1:0] i_cfg_shift,
    input  logic               i_cfg_relu_en,
    input  logic               i_cfg_half,
    input  logic               i_tile_start,
    input  logic [ADDR_W-1:0]  i_bias_addr_base,
    output logic [ADDR_W-1:0]  o_bias_addr,
    acc_bias_act_pipe_if.slave bus,
    output logic               o_tile_done,
    output logic [15:0]        o_sat_cnt
);
    localparam int SW = IN_W + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CH + 1);
    localparam logic signed [SW-1:0] MAX = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] MIN = ~MAX;

    logic                r_up;
    logic                w_acc, w_pop;
    logic [CH*SW-1:0]    w_sum, r1_sum;
    logic                r1_valid, r1_last, r1_relu, r1_half;
    logic [SHIFT_W-1:0]  r1_shift;
    logic [CH*OUT_W-1:0] w_res, r2_data;
    logic [CH-1:0]       w_sat;
    logic [CW-1:0]       w_nsat;
    logic [16:0]         w_sat_sum;
    logic                r2_valid, r2_last;
    logic [CH*OUT_W:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wp, r_rp;
    logic [AW:0]         r_cnt;

    assign w_acc = bus.i_in_valid && bus.o_in_ready;
    assign w_pop = bus.o_out_valid && bus.i_out_ready;
    assign bus.o_in_ready = r_up && ((r_cnt + (AW+1)'(r1_valid) + (AW+1)'(r2_valid)) < (AW+1)'(FIFO_DEPTH));
    assign bus.o_out_valid = r_cnt != '0;
    assign {bus.o_out_last, bus.o_out_data} = bus.o_out_valid ? r_mem[r_rp] : '0;
    assign o_tile_done = w_pop && bus.o_out_last;
    assign w_sat_sum = {1'b0, o_sat_cnt} + 17'(w_nsat);

    for (genvar g = 0; g < CH; g++) begin : g_lane
        localparam bit HI = g >= CH / 2;
        logic signed [SW-1:0] w_s, w_rnd, w_r;
        logic w_hi, w_lo, w_zero;
        assign w_sum[g*SW +: SW] = SW'($signed(bus.i_in_data[g*IN_W +: IN_W])) + SW'($signed(bus.i_bias[g*IN_W +: IN_W]));
        assign w_s = $signed(r1_sum[g*SW +: SW]);
        assign w_rnd = (r1_shift == '0) ? '0 : $signed(SW'(1) << (r1_shift - SHIFT_W'(1)));
        assign w_r = (w_s + w_rnd) >>> r1_shift;
        assign w_hi = w_r > MAX;
        assign w_lo = w_r < MIN;
        assign w_zero = (r1_half && HI) || (r1_relu && w_r[SW-1]);
        assign w_sat[g] = !w_zero && (w_hi || w_lo);
        assign w_res[g*OUT_W +: OUT_W] = w_zero ? '0 : w_hi ? MAX[OUT_W-1:0] : w_lo ? MIN[OUT_W-1:0] : w_r[OUT_W-1:0];
    end

    always_comb begin
        w_nsat = '0;
        for (int k = 0; k < CH; k++) w_nsat = w_nsat + CW'(w_sat[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up <= 1'b0;
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
            o_bias_addr <= '0;
            o_sat_cnt <= '0;
        end else begin
            r_up <= 1'b1;
            r1_valid <= w_acc;
            r2_valid <= r1_valid;
            if (r2_valid) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(r2_valid) - (AW+1)'(w_pop);
            if (i_tile_start) o_bias_addr <= i_bias_addr_base;
            else if (w_acc && bus.i_in_last) o_bias_addr <= o_bias_addr + ADDR_W'(CH);
            if (i_tile_start) o_sat_cnt <= '0;
            else if (r1_valid) o_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r1_sum <= w_sum;
            r1_last <= bus.i_in_last;
            r1_shift <= i_cfg_shift;
            r1_relu <= i_cfg_relu_en;
            r1_half <= i_cfg_half;
        end
        r2_data <= w_res;
        r2_last <= r1_last;
        if (r2_valid) r_mem[r_wp] <= {r2_last, r2_data};
    end
endmodule
